// File: rtl/fir_out_decim_fifo.sv
// ---------------------------------------------------------------------------
// fir_out_decim_fifo
//
// Output stage sitting directly behind the 51-tap low-pass FIR. The wide
// signed filter result is clipped to the system sample width and decimated
// by a fixed factor (the FIR's low-pass response does the anti-aliasing).
// Kept samples pass through one saturation register and are then buffered
// in a small first-word-fall-through FIFO. The consumer (DAC / UART framing)
// drains the FIFO with a valid/ready handshake. Clipping and FIFO overflow
// are reported through sticky status bits and a saturating drop counter.
//
// Parameters
//   IN_WIDTH    width of the signed filter output sample
//   OUT_WIDTH   width of the saturated output sample
//   DECIM       decimation factor (>=1), keep 1 of every DECIM valid inputs
//   FIFO_DEPTH  FIFO entries, power of two, >=2
//
// Ports
//   clk         single clock, everything on the rising edge
//   rst         asynchronous, active-high reset
//   in_valid    y_in carries a new filter sample this cycle
//   y_in        signed filter output sample
//   out_data    FIFO head sample, 0 while the FIFO is empty
//   out_valid   FIFO holds at least one sample
//   out_ready   consumer takes out_data when out_valid is also high
//   level       current FIFO occupancy
//   clr_status  synchronous clear of sat_flag, overflow and drop_count
//   sat_flag    sticky: a kept sample was clipped
//   overflow    sticky: a kept sample was lost because the FIFO was full
//   drop_count  number of lost samples, holds at 255
// ---------------------------------------------------------------------------
module fir_out_decim_fifo #(
  parameter int IN_WIDTH   = 39,
  parameter int OUT_WIDTH  = 16,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic signed [IN_WIDTH-1:0]          y_in,
  output logic signed [OUT_WIDTH-1:0]         out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(FIFO_DEPTH):0]         level,
  input  logic                                clr_status,
  output logic                                sat_flag,
  output logic                                overflow,
  output logic [7:0]                          drop_count
);

  // A decimation factor of 1 still needs a (constant zero) phase register
  // of at least one bit.
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  // Saturation thresholds expressed at the input width, plus the clipped
  // output codes at the output width.
  localparam logic signed [IN_WIDTH-1:0] IN_MAX =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] IN_MIN =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [PW-1:0]                phase;
  logic                         keep;
  logic signed [OUT_WIDTH-1:0]  sat_next;
  logic                         clip;
  logic                         sat_valid;
  logic signed [OUT_WIDTH-1:0]  sat_data;

  logic signed [OUT_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                rd_ptr;
  logic [LW-1:0]                count;
  logic                         full;
  logic                         empty;
  logic                         rd_en;
  logic                         wr_en;
  logic                         drop;

  // Decimation phase only moves on valid inputs, so gaps in the input
  // stream do not disturb which samples are kept. Phase 0 is the keeper,
  // which makes the first valid sample after reset the first one kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (in_valid) begin
      if (phase == PW'(DECIM - 1))
        phase <= '0;
      else
        phase <= phase + PW'(1);
    end
  end

  assign keep = in_valid && (phase == '0);

  // Clip the wide sample into the output range. In-range values keep
  // their low bits unchanged, which is exact for two's complement.
  always_comb begin
    sat_next = y_in[OUT_WIDTH-1:0];
    clip     = 1'b0;
    if (y_in > IN_MAX) begin
      sat_next = OUT_MAX;
      clip     = 1'b1;
    end else if (y_in < IN_MIN) begin
      sat_next = OUT_MIN;
      clip     = 1'b1;
    end
  end

  // One pipeline stage between the filter and the FIFO. Data is only
  // loaded for kept samples; the valid bit qualifies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_valid <= 1'b0;
      sat_data  <= '0;
    end else begin
      sat_valid <= keep;
      if (keep)
        sat_data <= sat_next;
    end
  end

  // FIFO control. A full FIFO still accepts a write when the head is being
  // read in the same cycle. An empty FIFO never forwards the incoming
  // sample combinationally: it lands in storage and appears next cycle.
  assign empty     = (count == '0);
  assign full      = (count == LW'(FIFO_DEPTH));
  assign out_valid = !empty;
  assign rd_en     = out_valid && out_ready;
  assign wr_en     = sat_valid && (!full || rd_en);
  assign drop      = sat_valid && full && !rd_en;

  // Sample storage has no reset; stale entries are unreachable once the
  // pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= sat_data;
  end

  // Pointers wrap naturally because the depth is a power of two; the
  // separate occupancy counter disambiguates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign level    = count;
  assign out_data = empty ? '0 : mem[rd_ptr];

  // Sticky status. A clear and a new event in the same cycle resolve in
  // favour of the event, so nothing that happens during a clear is lost;
  // the drop counter then restarts at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag   <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (clr_status) begin
        sat_flag   <= 1'b0;
        overflow   <= 1'b0;
        drop_count <= '0;
      end
      if (keep && clip)
        sat_flag <= 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (clr_status)
          drop_count <= 8'd1;
        else if (drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/fir_out_decim_fifo.md
# fir_out_decim_fifo

Output stage directly downstream of the 51-tap low-pass FIR. Takes the filter's wide signed result, saturates it to the system sample width, and decimates by a fixed factor; the low-pass response provides anti-aliasing. Kept samples are buffered in a small first-word-fall-through FIFO and drained through a valid/ready handshake to the consumer (DAC/UART framing logic). Saturation events and FIFO overflow are reported through sticky status.

## Interface
- IN_WIDTH, 39, width of filter output sample (DATA_WIDTH+COEFF_WIDTH+7)
- OUT_WIDTH, 16, width of saturated output sample
- DECIM, 4, decimation factor (≥1); keep 1 of every DECIM valid inputs
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥2
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset; asynchronous and active-high
- in_valid  input  1  y_in holds a new filter sample this cycle
- y_in  input  IN_WIDTH signed  filter output sample
- out_data  output  OUT_WIDTH signed  FIFO head sample; 0 when empty
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts out_data when out_valid is also high
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- clr_status  input  1  synchronous clear of sat_flag, overflow, drop_count
- sat_flag  output  1  sticky: a kept sample was clipped
- overflow  output  1  sticky: a kept sample was dropped because FIFO was full
- drop_count  output  8  dropped-sample count, saturates at 255

## Operation
- Decimation phase counter 0..DECIM-1, advances only on in_valid, wraps DECIM-1→0. Sample kept when in_valid && phase==0. First valid sample after reset is kept.
- Saturation (kept samples only): y_in > 2^(OUT_WIDTH-1)-1 → max positive; y_in < -2^(OUT_WIDTH-1) → max negative; else low OUT_WIDTH bits unchanged. Clipped sample sets sat_flag. Result registered in one pipeline stage (sat_valid, sat_data).
- FIFO write when sat_valid. Read when out_valid && out_ready (pointer advance; data already presented at head).
- Full and write without read: sample dropped, FIFO unchanged, overflow←1, drop_count+1 (hold at 255).
- Full with simultaneous read and write: both accepted, level unchanged, no drop.
- Empty with sat_valid and out_ready: write only (no fall-through in same cycle); out_valid rises next cycle.
- Pointers wrap modulo FIFO_DEPTH; level tracks writes minus reads.
- clr_status clears the three status outputs; if a drop or clip occurs in the same cycle, the new event wins (flag set, drop_count=1).
- DECIM=1: every valid sample kept.

## Timing
- Reset (async, immediate on rst high, independent of clk): out_valid 0, out_data 0, level 0, sat_flag 0, overflow 0, drop_count 0, phase 0, sat_valid 0, FIFO pointers 0. In-flight pipeline sample and FIFO contents discarded.
- Latency: kept sample captured on edge n → sat register at edge n → FIFO write at edge n+1 → out_valid high and out_data valid after edge n+1 (2 edges, FIFO previously empty).
- Sustained throughput: one kept sample per cycle accepted into FIFO; one read per cycle.
- out_data is stable while out_valid && !out_ready (no change until handshake).
- Status outputs update on the edge after the causing event; level updates on the edge of the write/read.

## Test plan
- DECIM=4, in_valid=1 every cycle, y_in ramp 0,1,2,…, out_ready=1 → out_data 0,4,8,12,…; out_valid first high after 2nd edge following first sample; level never exceeds 1.
- Saturation: kept y_in = 40000, -40000, 32767, -32768 → out_data 32767, -32768, 32767, -32768; sat_flag 0 after the in-range samples alone, 1 once 40000 is kept; clr_status returns it to 0.
- Overflow: DECIM=1, out_ready=0, 10 valid samples 1..10 → level 8, overflow 1, drop_count 2; then out_ready=1 drains 1..8 in order, out_valid falls after 8th read.
- Full boundary: FIFO at 8, out_ready=1 and new kept sample same cycle → level stays 8, no drop, drop_count unchanged; in_valid gaps (valid every 3rd cycle) with DECIM=2 → phase advances only on valid, every 2nd valid sample emitted.
- Async reset mid-stream: FIFO level 5, rst asserted between edges → out_valid, level, flags 0 immediately; after release, next valid y_in=77 appears as out_data 77 two edges later.
